// File: rtl/pma_region_table.sv
// Programmable PMA region table: NrRules lockable entries,
// NrChannels independent lookup ports with a registered response.
module pma_region_table #(
  parameter int NrRules    = 8,
  parameter int NrChannels = 2,
  parameter int AddrWidth  = 64,
  parameter int DataWidth  = 64,
  localparam int IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_we_i,
  input  logic [IdxW-1:0]                cfg_idx_i,
  input  logic [1:0]                     cfg_sel_i,
  input  logic [DataWidth-1:0]           cfg_wdata_i,
  output logic [DataWidth-1:0]           cfg_rdata_o,
  input  logic [NrChannels-1:0]          req_valid_i,
  output logic [NrChannels-1:0]          req_ready_o,
  input  logic [NrChannels*AddrWidth-1:0] req_addr_i,
  output logic [NrChannels-1:0]          resp_valid_o,
  input  logic [NrChannels-1:0]          resp_ready_i,
  output logic [NrChannels-1:0]          resp_hit_o,
  output logic [NrChannels*3-1:0]        resp_attr_o,
  output logic [NrChannels*IdxW-1:0]     resp_idx_o
);

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [4:0]           attr_q [NrRules];

  logic [31:0] idx32;
  logic        idx_ok;
  logic        wr_ok;
  logic [DataWidth-1:0] rd_next;

  assign idx32  = 32'(cfg_idx_i);
  assign idx_ok = idx32 < NrRules;
  assign wr_ok  = cfg_we_i & idx_ok
                & ~attr_q[cfg_idx_i][4];

  // Table storage; locked entries ignore every field write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        attr_q[i] <= '0;
      end
    end else if (wr_ok) begin
      case (cfg_sel_i)
        2'd0: base_q[cfg_idx_i] <= cfg_wdata_i[AddrWidth-1:0];
        2'd1: len_q[cfg_idx_i]  <= cfg_wdata_i[AddrWidth-1:0];
        2'd2: attr_q[cfg_idx_i] <= cfg_wdata_i[4:0];
        default: ;
      endcase
    end
  end

  // Read-back value including a write landing on the same edge.
  always_comb begin
    rd_next = '0;
    if (idx_ok) begin
      case (cfg_sel_i)
        2'd0: rd_next = DataWidth'(base_q[cfg_idx_i]);
        2'd1: rd_next = DataWidth'(len_q[cfg_idx_i]);
        2'd2: rd_next = DataWidth'(attr_q[cfg_idx_i]);
        default: rd_next = '0;
      endcase
      if (wr_ok) begin
        case (cfg_sel_i)
          2'd0, 2'd1:
            rd_next = DataWidth'(cfg_wdata_i[AddrWidth-1:0]);
          2'd2: rd_next = DataWidth'(cfg_wdata_i[4:0]);
          default: rd_next = '0;
        endcase
      end
    end
  end

  // Registered programming read port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cfg_rdata_o <= '0;
    else       cfg_rdata_o <= rd_next;
  end

  logic [AddrWidth-1:0] lk_addr [NrChannels];
  logic                 lk_hit  [NrChannels];
  logic [2:0]           lk_attr [NrChannels];
  logic [IdxW-1:0]      lk_idx  [NrChannels];

  logic                 rv_q    [NrChannels];
  logic                 hit_q   [NrChannels];
  logic [2:0]           attr_o_q[NrChannels];
  logic [IdxW-1:0]      idx_q   [NrChannels];
  logic [NrChannels-1:0] accept;

  for (genvar c = 0; c < NrChannels; c++) begin : g_ch
    assign lk_addr[c] = req_addr_i[c*AddrWidth +: AddrWidth];
    assign req_ready_o[c]  = ~rv_q[c] | resp_ready_i[c];
    assign accept[c]       = req_valid_i[c] & req_ready_o[c];
    assign resp_valid_o[c] = rv_q[c];
    assign resp_hit_o[c]   = hit_q[c];
    assign resp_attr_o[c*3 +: 3]     = attr_o_q[c];
    assign resp_idx_o[c*IdxW +: IdxW] = idx_q[c];
  end

  // Priority match; scanning downward leaves the lowest index.
  // The end bound uses one extra bit so top-of-space never wraps.
  always_comb begin
    for (int c = 0; c < NrChannels; c++) begin
      lk_hit[c]  = 1'b0;
      lk_attr[c] = 3'b000;
      lk_idx[c]  = '0;
      for (int i = NrRules - 1; i >= 0; i--) begin
        if (attr_q[i][3] && (len_q[i] != '0)
            && (lk_addr[c] >= base_q[i])
            && ({1'b0, lk_addr[c]}
                < ({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
          lk_hit[c]  = 1'b1;
          lk_attr[c] = attr_q[i][2:0];
          lk_idx[c]  = IdxW'(i);
        end
      end
    end
  end

  // One response register per channel with valid/ready hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NrChannels; c++) begin
        rv_q[c]     <= 1'b0;
        hit_q[c]    <= 1'b0;
        attr_o_q[c] <= '0;
        idx_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NrChannels; c++) begin
        if (accept[c]) begin
          rv_q[c]     <= 1'b1;
          hit_q[c]    <= lk_hit[c];
          attr_o_q[c] <= lk_attr[c];
          idx_q[c]    <= lk_idx[c];
        end else if (resp_ready_i[c]) begin
          rv_q[c] <= 1'b0;
        end
      end
    end
  end

endmodule
